// File: rtl/alu_arbiter_if.sv
// Bundle of requester, alu-side and response signals around alu_arbiter.
// The arbiter takes the slave view; the surrounding environment takes the master view.
interface alu_arbiter_if #(parameter int SIZE = 2);
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [3:0]        req_command0;
  logic [SIZE-1:0]   req_a0;
  logic [SIZE-1:0]   req_b0;
  logic [3:0]        req_command1;
  logic [SIZE-1:0]   req_a1;
  logic [SIZE-1:0]   req_b1;
  logic              alu_enable;
  logic [3:0]        alu_command;
  logic [SIZE-1:0]   alu_a;
  logic [SIZE-1:0]   alu_b;
  logic              alu_overflow;
  logic [2*SIZE-1:0] alu_result;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic              rsp_error;
  logic              rsp_overflow;
  logic [2*SIZE-1:0] rsp_result;

  modport slave (
    input  req_valid, req_command0, req_a0, req_b0, req_command1, req_a1, req_b1,
    input  alu_overflow, alu_result, rsp_ready,
    output req_ready, alu_enable, alu_command, alu_a, alu_b,
    output rsp_valid, rsp_id, rsp_error, rsp_overflow, rsp_result
  );

  modport master (
    output req_valid, req_command0, req_a0, req_b0, req_command1, req_a1, req_b1,
    output alu_overflow, alu_result, rsp_ready,
    input  req_ready, alu_enable, alu_command, alu_a, alu_b,
    input  rsp_valid, rsp_id, rsp_error, rsp_overflow, rsp_result
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational alu between two requesters,
// with a single op in flight and a registered response held until consumed.
module alu_arbiter #(
  parameter int SIZE = 2
) (
  input  logic       clk,
  input  logic       reset,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state;
  logic              ptr;
  logic [1:0]        grant;
  logic              xfer;
  logic              sel;
  logic [3:0]        cmd_in;
  logic [SIZE-1:0]   a_in;
  logic [SIZE-1:0]   b_in;

  logic [3:0]        cmd_q;
  logic [SIZE-1:0]   a_q;
  logic [SIZE-1:0]   b_q;
  logic              alu_en_q;
  logic              rsp_valid_q;
  logic              rsp_id_q;
  logic              rsp_error_q;
  logic              rsp_overflow_q;
  logic [2*SIZE-1:0] rsp_result_q;

  // The pointer side wins a tie; a lone requester always wins.
  always_comb begin
    // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
    grant = 2'b00;
    if (state == IDLE) begin
      if (&bus.req_valid) grant = ptr ? 2'b10 : 2'b01;
      else                grant = bus.req_valid;
    end
  end

  assign xfer   = |(bus.req_valid & grant);
  assign sel    = grant[1];
  assign cmd_in = sel ? bus.req_command1 : bus.req_command0;
  assign a_in   = sel ? bus.req_a1 : bus.req_a0;
  assign b_in   = sel ? bus.req_b1 : bus.req_b0;

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous here, so it lives inside the clocked block, not in the sensitivity list.
    if (reset) begin
      state          <= IDLE;
      ptr            <= 1'b0;
      cmd_q          <= '0;
      a_q            <= '0;
      b_q            <= '0;
      alu_en_q       <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= 1'b0;
      rsp_error_q    <= 1'b0;
      rsp_overflow_q <= 1'b0;
      rsp_result_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        IDLE: if (xfer) begin
          cmd_q    <= cmd_in;
          a_q      <= a_in;
          b_q      <= b_in;
          rsp_id_q <= sel;
          if (cmd_in >= 4'd12) begin
            // Unimplemented command: skip the alu and answer with an error next cycle.
            rsp_error_q    <= 1'b1;
            rsp_overflow_q <= 1'b0;
            rsp_result_q   <= '0;
            rsp_valid_q    <= 1'b1;
            state          <= RESP;
          end else begin
            alu_en_q <= 1'b1;
            state    <= EXEC;
          end
        end
        EXEC: begin
          alu_en_q       <= 1'b0;
          rsp_result_q   <= bus.alu_result;
          rsp_overflow_q <= bus.alu_overflow;
          rsp_error_q    <= 1'b0;
          rsp_valid_q    <= 1'b1;
          state          <= RESP;
        end
        RESP: if (bus.rsp_ready) begin
          rsp_valid_q <= 1'b0;
          ptr         <= ~rsp_id_q;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready    = grant;
  assign bus.alu_enable   = alu_en_q;
  assign bus.alu_command  = cmd_q;
  assign bus.alu_a        = a_q;
  assign bus.alu_b        = b_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_error    = rsp_error_q;
  assign bus.rsp_overflow = rsp_overflow_q;
  assign bus.rsp_result   = rsp_result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, reset/alternation sequences,
// and randomized traffic against a transaction-level reference model with a behavioural alu.
module tb_alu_arbiter;
  localparam int SIZE = 2;
  localparam int W    = 2 * SIZE;
  localparam int MAXA = (1 << SIZE) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_arbiter_if #(.SIZE(SIZE)) bus ();
  alu_arbiter #(.SIZE(SIZE)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Behavioural alu that sits beside the arbiter: {overflow, result}.
  function automatic logic [W:0] alu_ref(input logic [3:0] c, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
    int ia, ib, r;
    logic o;
    ia = int'(a); ib = int'(b); o = 1'b0; r = 0;
    case (c)
      4'd0: r = ia & ib;
      4'd1: r = ia | ib;
      4'd2: r = ia ^ ib;
      4'd3: r = ia >> 1;
      4'd4: begin r = ia + ib; o = (r > MAXA); end
      4'd5: begin r = ia - ib; o = (ib > ia); end
      4'd6: r = ia * ib;
      4'd7: r = (~ia) & MAXA;
      4'd8, 4'd9, 4'd10, 4'd11: r = ia << c[1:0];
      default: r = 0;
    endcase
    r = r & ((1 << W) - 1);
    return {o, r[W-1:0]};
  endfunction

  always_comb begin
    {bus.alu_overflow, bus.alu_result} = bus.alu_enable ? alu_ref(bus.alu_command, bus.alu_a, bus.alu_b) : '0;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] winner(input logic [1:0] v, input logic p);
    if (v == 2'b11) return p ? 2'b10 : 2'b01;
    return v;
  endfunction

  // Reference model: one op in flight, tracked by its transfer cycle.
  int              cyc = 0;
  logic            m_busy = 1'b0, m_ptr = 1'b0;
  logic            m_id, m_err, m_ovf;
  logic [3:0]      m_cmd;
  logic [SIZE-1:0] m_a, m_b;
  logic [W-1:0]    m_res;
  int              m_xc;
  logic            xfer_flag, xfer_id, hs_flag;
  logic            hs_id, hs_err, hs_ovf;
  logic [W-1:0]    hs_res;

  task automatic step();
    logic [1:0] exp_rdy;
    logic exp_en, exp_rv;
    logic [W:0] r;
    @(negedge clk);
    xfer_flag = 1'b0; hs_flag = 1'b0;
    exp_rdy = m_busy ? 2'b00 : winner(bus.req_valid, m_ptr);
    exp_en  = m_busy && !m_err && (cyc == m_xc + 1);
    exp_rv  = m_busy && (cyc >= m_xc + (m_err ? 1 : 2));
    check("req_ready", bus.req_ready, exp_rdy);
    check("ready_onehot", 32'($countones(bus.req_ready) <= 1), 1);
    check("alu_enable", bus.alu_enable, exp_en);
    check("rsp_valid", bus.rsp_valid, exp_rv);
    if (exp_en) begin
      check("alu_command", bus.alu_command, m_cmd);
      check("alu_a", bus.alu_a, m_a);
      check("alu_b", bus.alu_b, m_b);
    end
    if (exp_rv) begin
      check("rsp_id", bus.rsp_id, m_id);
      check("rsp_error", bus.rsp_error, m_err);
      check("rsp_overflow", bus.rsp_overflow, m_ovf);
      check("rsp_result", bus.rsp_result, m_res);
    end
    if (reset) begin
      m_busy = 1'b0; m_ptr = 1'b0;
    end else if (!m_busy && |(bus.req_valid & exp_rdy)) begin
      xfer_flag = 1'b1;
      m_id  = exp_rdy[1];
      xfer_id = m_id;
      m_cmd = m_id ? bus.req_command1 : bus.req_command0;
      m_a   = m_id ? bus.req_a1 : bus.req_a0;
      m_b   = m_id ? bus.req_b1 : bus.req_b0;
      m_err = (m_cmd >= 4'd12);
      r = alu_ref(m_cmd, m_a, m_b);
      m_ovf = m_err ? 1'b0 : r[W];
      m_res = m_err ? '0 : r[W-1:0];
      m_xc = cyc;
      m_busy = 1'b1;
    end else if (exp_rv && bus.rsp_ready) begin
      hs_flag = 1'b1;
      hs_id = bus.rsp_id; hs_err = bus.rsp_error; hs_ovf = bus.rsp_overflow; hs_res = bus.rsp_result;
      m_busy = 1'b0;
      m_ptr = ~m_id;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, bus.req_ready, 0);
    check({tag, "_alu_enable"}, bus.alu_enable, 0);
    check({tag, "_alu_command"}, bus.alu_command, 0);
    check({tag, "_alu_a"}, bus.alu_a, 0);
    check({tag, "_alu_b"}, bus.alu_b, 0);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check({tag, "_rsp_id"}, bus.rsp_id, 0);
    check({tag, "_rsp_error"}, bus.rsp_error, 0);
    check({tag, "_rsp_overflow"}, bus.rsp_overflow, 0);
    check({tag, "_rsp_result"}, bus.rsp_result, 0);
  endtask

  typedef struct {
    logic [1:0]      valid;
    logic [3:0]      c0;
    logic [SIZE-1:0] a0, b0;
    logic [3:0]      c1;
    logic [SIZE-1:0] a1, b1;
    int              hold;
    logic            exp_id, exp_err, exp_ovf;
    logic [W-1:0]    exp_res;
  } vec_t;

  vec_t tbl [10];

  task automatic run_vec(input vec_t v, input int k);
    bit done;
    bus.req_valid = v.valid;
    bus.req_command0 = v.c0; bus.req_a0 = v.a0; bus.req_b0 = v.b0;
    bus.req_command1 = v.c1; bus.req_a1 = v.a1; bus.req_b1 = v.b1;
    bus.rsp_ready = 1'b0;
    done = 0;
    for (int t = 0; t < 8 && !done; t++) begin
      step();
      done = xfer_flag;
    end
    check($sformatf("vec%0d_transfer", k), 32'(done), 1);
    bus.req_valid = 2'b00;
    if (!done) return;
    check($sformatf("vec%0d_grant_id", k), xfer_id, v.exp_id);
    for (int h = 0; h < v.hold; h++) step();
    bus.rsp_ready = 1'b1;
    done = 0;
    for (int t = 0; t < 8 && !done; t++) begin
      step();
      done = hs_flag;
    end
    bus.rsp_ready = 1'b0;
    check($sformatf("vec%0d_response", k), 32'(done), 1);
    if (!done) return;
    check($sformatf("vec%0d_id", k), hs_id, v.exp_id);
    check($sformatf("vec%0d_error", k), hs_err, v.exp_err);
    check($sformatf("vec%0d_overflow", k), hs_ovf, v.exp_ovf);
    check($sformatf("vec%0d_result", k), hs_res, v.exp_res);
  endtask

  task automatic new_op(input int i);
    logic       v;
    logic [3:0] c;
    v = ($urandom_range(3) != 0);
    c = 4'($urandom_range(15));
    bus.req_valid[i] = v;
    if (i == 0) begin
      bus.req_command0 = c; bus.req_a0 = SIZE'($urandom); bus.req_b0 = SIZE'($urandom);
    end else begin
      bus.req_command1 = c; bus.req_a1 = SIZE'($urandom); bus.req_b1 = SIZE'($urandom);
    end
  endtask

  initial begin
    int got [4];
    int n;
    bit done;
    //          valid  c0  a0 b0  c1  a1 b1 hold id err ovf res
    tbl[0] = '{2'b01, 0,  3, 1, 0,  0, 0, 0,  0, 0, 0, 1};
    tbl[1] = '{2'b10, 0,  0, 0, 3,  2, 0, 5,  1, 0, 0, 1};
    tbl[2] = '{2'b10, 0,  0, 0, 2,  2, 3, 0,  1, 0, 0, 1};
    tbl[3] = '{2'b01, 13, 3, 3, 0,  0, 0, 2,  0, 1, 0, 0};
    tbl[4] = '{2'b01, 4,  3, 3, 0,  0, 0, 0,  0, 0, 1, 6};
    tbl[5] = '{2'b10, 0,  0, 0, 5,  1, 2, 1,  1, 0, 1, 15};
    tbl[6] = '{2'b01, 6,  3, 2, 0,  0, 0, 0,  0, 0, 0, 6};
    tbl[7] = '{2'b11, 4,  1, 1, 1,  2, 1, 0,  1, 0, 0, 3};
    tbl[8] = '{2'b11, 7,  1, 0, 0,  3, 3, 0,  0, 0, 0, 2};
    tbl[9] = '{2'b10, 0,  0, 0, 12, 3, 3, 0,  1, 1, 0, 0};

    reset = 1'b1;
    bus.req_valid = 2'b00; bus.rsp_ready = 1'b0;
    bus.req_command0 = '0; bus.req_a0 = '0; bus.req_b0 = '0;
    bus.req_command1 = '0; bus.req_a1 = '0; bus.req_b1 = '0;
    @(posedge clk); #1;
    repeat (2) step();
    reset = 1'b0;
    check_all_zero("reset");

    foreach (tbl[k]) run_vec(tbl[k], k);

    // Reset while the op is in EXEC: no response may follow.
    bus.req_valid = 2'b01; bus.req_command0 = 4'd4; bus.req_a0 = 1; bus.req_b0 = 1;
    done = 0;
    for (int t = 0; t < 8 && !done; t++) begin
      step();
      done = xfer_flag;
    end
    check("abort_transfer", 32'(done), 1);
    bus.req_valid = 2'b00;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_all_zero("abort");
    bus.rsp_ready = 1'b1;
    repeat (4) step();

    // Both requesters held valid from reset state: grants alternate 0,1,0,1.
    bus.req_valid = 2'b11; bus.req_command0 = 4'd1; bus.req_command1 = 4'd2;
    n = 0;
    for (int t = 0; t < 20 && n < 4; t++) begin
      step();
      if (xfer_flag) begin got[n] = int'(xfer_id); n++; end
    end
    check("alternate_count", n, 4);
    for (int i = 0; i < n; i++) check($sformatf("alternate_%0d", i), got[i], i % 2);
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b0;
    repeat (3) step();

    for (int t = 0; t < 3000; t++) begin
      reset = ($urandom_range(199) == 0);
      bus.rsp_ready = $urandom_range(1);
      step();
      for (int i = 0; i < 2; i++)
        if ((xfer_flag && int'(xfer_id) == i) || $urandom_range(4) == 0) new_op(i);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
